// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: a single-outstanding word fetcher feeding the IF/ID register, with
// stall buffering and decode redirects. Define IF_DELAY_SLOT_EN to deliver the delay-slot word.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ID_Stall,
  input  logic        ID_PCSrc,
  input  logic [31:0] ID_PCBranch,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_Ins,
  output logic [31:0] IF_ID_PC_P1,
  output logic        IF_ID_Valid,
  output logic [1:0]  dbg_state
);

`ifdef IF_DELAY_SLOT_EN
  localparam bit DelaySlotEn = 1'b1;
`else
  localparam bit DelaySlotEn = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, FULL = 2'd2, DRAIN = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] p1_q, p1_d;
  logic        valid_q, valid_d;
  logic        pend_q, pend_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] buf_ins_q, buf_ins_d;
  logic [31:0] buf_p1_q, buf_p1_d;
  logic        redir_ok;
  logic [31:0] pc_inc;

  // Handshake: imem_req/imem_addr are held from the first request cycle until the cycle
  // imem_ready=1; a word transfers on the rising edge where both imem_req and imem_ready are high.
  assign imem_req    = (state_q == WAIT) || (state_q == DRAIN);
  assign imem_addr   = pc_q;
  assign IF_ID_Ins   = ins_q;
  assign IF_ID_PC_P1 = p1_q;
  assign IF_ID_Valid = valid_q;
  assign dbg_state   = state_q;

  assign pc_inc   = pc_q + 32'd1;
  assign redir_ok = ID_PCSrc && !ID_Stall && valid_q && !pend_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ins_d     = ins_q;
    p1_d      = p1_q;
    valid_d   = valid_q;
    pend_d    = pend_q;
    tgt_d     = tgt_q;
    buf_ins_d = buf_ins_q;
    buf_p1_d  = buf_p1_q;
    if (redir_ok) tgt_d = ID_PCBranch;
    case (state_q)
      IDLE: state_d = WAIT;
      WAIT: begin
        if (ID_Stall) begin
          if (imem_ready) begin
            buf_ins_d = imem_rdata;
            buf_p1_d  = pc_inc;
            state_d   = FULL;
          end
        end else if (imem_ready) begin
          if (redir_ok) begin
            // The word completing now is the delay slot of the redirecting instruction.
            if (DelaySlotEn) begin
              ins_d   = imem_rdata;
              p1_d    = pc_inc;
              valid_d = 1'b1;
            end else begin
              ins_d   = 32'h0;
              valid_d = 1'b0;
            end
            pc_d = ID_PCBranch;
          end else begin
            ins_d   = imem_rdata;
            p1_d    = pc_inc;
            valid_d = 1'b1;
            pc_d    = pc_inc;
          end
        end else begin
          ins_d   = 32'h0;
          valid_d = 1'b0;
          if (redir_ok) begin
            pend_d  = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (imem_ready) begin
          if (ID_Stall && DelaySlotEn) begin
            // Delay slot must wait out the stall; FULL finishes the redirect.
            buf_ins_d = imem_rdata;
            buf_p1_d  = pc_inc;
            state_d   = FULL;
          end else begin
            if (!ID_Stall) begin
              if (DelaySlotEn) begin
                ins_d   = imem_rdata;
                p1_d    = pc_inc;
                valid_d = 1'b1;
              end else begin
                ins_d   = 32'h0;
                valid_d = 1'b0;
              end
            end
            pc_d    = tgt_q;
            pend_d  = 1'b0;
            state_d = WAIT;
          end
        end else if (!ID_Stall) begin
          ins_d   = 32'h0;
          valid_d = 1'b0;
        end
      end
      FULL: begin
        if (!ID_Stall) begin
          state_d = WAIT;
          if (pend_q) begin
            ins_d   = buf_ins_q;
            p1_d    = buf_p1_q;
            valid_d = 1'b1;
            pc_d    = tgt_q;
            pend_d  = 1'b0;
          end else if (redir_ok) begin
            if (DelaySlotEn) begin
              ins_d   = buf_ins_q;
              p1_d    = buf_p1_q;
              valid_d = 1'b1;
            end else begin
              ins_d   = 32'h0;
              valid_d = 1'b0;
            end
            pc_d = ID_PCBranch;
          end else begin
            ins_d   = buf_ins_q;
            p1_d    = buf_p1_q;
            valid_d = 1'b1;
            pc_d    = pc_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      ins_q     <= 32'h0;
      p1_q      <= RESET_PC;
      valid_q   <= 1'b0;
      pend_q    <= 1'b0;
      tgt_q     <= 32'h0;
      buf_ins_q <= 32'h0;
      buf_p1_q  <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ins_q     <= ins_d;
      p1_q      <= p1_d;
      valid_q   <= valid_d;
      pend_q    <= pend_d;
      tgt_q     <= tgt_d;
      buf_ins_q <= buf_ins_d;
      buf_p1_q  <= buf_p1_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; memory returns its address as data.
// Observed vector layout: {imem_req, imem_addr, IF_ID_Ins, IF_ID_PC_P1, IF_ID_Valid}.
module tb_if_fetch_stage;

`ifdef IF_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ID_Stall = 1'b0;
  logic        ID_PCSrc = 1'b0;
  logic [31:0] ID_PCBranch = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] IF_ID_Ins;
  logic [31:0] IF_ID_PC_P1;
  logic        IF_ID_Valid;
  logic [1:0]  dbg_state;

  logic [97:0] obs;
  logic [97:0] exp_v;
  int          errors = 0;
  int          checks = 0;

  assign obs = {imem_req, imem_addr, IF_ID_Ins, IF_ID_PC_P1, IF_ID_Valid};

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .ID_Stall(ID_Stall), .ID_PCSrc(ID_PCSrc), .ID_PCBranch(ID_PCBranch),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .IF_ID_Ins(IF_ID_Ins), .IF_ID_PC_P1(IF_ID_PC_P1), .IF_ID_Valid(IF_ID_Valid), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // One clock: inputs applied at the falling edge, outputs observed 1 time unit after the rise.
  task automatic cycle(input logic rdy, input logic stl, input logic src, input logic [31:0] tgt);
    @(negedge clk);
    imem_ready  = rdy;
    imem_rdata  = imem_addr;
    ID_Stall    = stl;
    ID_PCSrc    = src;
    ID_PCBranch = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    checks++; exp_v = {1'b0, 32'h0, 32'h0, 32'h0, 1'b0};
    if (obs !== exp_v) begin errors++; $display("FAIL reset_async: got %h required %h", obs, exp_v); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_idle_state: got %0d required 0", dbg_state); end
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_idle_out: got %h required %h", obs, exp_v); end
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; exp_v = {1'b1, 32'h0, 32'h0, 32'h0, 1'b0};
    if (obs !== exp_v) begin errors++; $display("FAIL reset_first_wait: got %h required %h", obs, exp_v); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      checks++; exp_v = {1'b1, 32'(i + 1), 32'(i), 32'(i + 1), 1'b1};
      if (obs !== exp_v) begin errors++; $display("FAIL b2b_%0d: got %h required %h", i, obs, exp_v); end
    end
  endtask

  task automatic test_stall;
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; exp_v = {1'b1, 32'h5, 32'h4, 32'h5, 1'b1};
    if (obs !== exp_v) begin errors++; $display("FAIL stall_pre: got %h required %h", obs, exp_v); end
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    exp_v = {1'b0, 32'h5, 32'h4, 32'h5, 1'b1};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL stall_c1: got %h required %h", obs, exp_v); end
    checks++;
    if (dbg_state !== 2'd2) begin errors++; $display("FAIL stall_full_state: got %0d required 2", dbg_state); end
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL stall_c2: got %h required %h", obs, exp_v); end
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL stall_c3: got %h required %h", obs, exp_v); end
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; exp_v = {1'b1, 32'h6, 32'h5, 32'h6, 1'b1};
    if (obs !== exp_v) begin errors++; $display("FAIL stall_release: got %h required %h", obs, exp_v); end
  endtask

  task automatic test_redirect_wait;
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; exp_v = {1'b1, 32'h8, 32'h7, 32'h8, 1'b1};
    if (obs !== exp_v) begin errors++; $display("FAIL redir_pre: got %h required %h", obs, exp_v); end
    cycle(1'b0, 1'b0, 1'b1, 32'h40);
    exp_v = {1'b1, 32'h8, 32'h0, 32'h8, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL redir_drain1: got %h required %h", obs, exp_v); end
    checks++;
    if (dbg_state !== 2'd3) begin errors++; $display("FAIL redir_drain_state: got %0d required 3", dbg_state); end
    cycle(1'b0, 1'b0, 1'b1, 32'h40);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL redir_drain2: got %h required %h", obs, exp_v); end
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    exp_v = DS ? {1'b1, 32'h40, 32'h8, 32'h9, 1'b1} : {1'b1, 32'h40, 32'h0, 32'h8, 1'b0};
    if (obs !== exp_v) begin errors++; $display("FAIL redir_done: got %h required %h", obs, exp_v); end
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; exp_v = {1'b1, 32'h41, 32'h40, 32'h41, 1'b1};
    if (obs !== exp_v) begin errors++; $display("FAIL redir_target: got %h required %h", obs, exp_v); end
  endtask

  task automatic test_redirect_ready;
    cycle(1'b1, 1'b0, 1'b1, 32'h80);
    checks++;
    exp_v = DS ? {1'b1, 32'h80, 32'h41, 32'h42, 1'b1} : {1'b1, 32'h80, 32'h0, 32'h41, 1'b0};
    if (obs !== exp_v) begin errors++; $display("FAIL redir0_edge: got %h required %h", obs, exp_v); end
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; exp_v = {1'b1, 32'h81, 32'h80, 32'h81, 1'b1};
    if (obs !== exp_v) begin errors++; $display("FAIL redir0_target: got %h required %h", obs, exp_v); end
  endtask

  task automatic test_stall_redirect;
    cycle(1'b0, 1'b1, 1'b1, 32'h100);
    checks++; exp_v = {1'b1, 32'h81, 32'h80, 32'h81, 1'b1};
    if (obs !== exp_v) begin errors++; $display("FAIL stallsrc_hold: got %h required %h", obs, exp_v); end
    cycle(1'b0, 1'b0, 1'b1, 32'h100);
    checks++; exp_v = {1'b1, 32'h81, 32'h0, 32'h81, 1'b0};
    if (obs !== exp_v) begin errors++; $display("FAIL stallsrc_taken: got %h required %h", obs, exp_v); end
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    exp_v = DS ? {1'b1, 32'h100, 32'h81, 32'h82, 1'b1} : {1'b1, 32'h100, 32'h0, 32'h81, 1'b0};
    if (obs !== exp_v) begin errors++; $display("FAIL stallsrc_done: got %h required %h", obs, exp_v); end
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; exp_v = {1'b1, 32'h101, 32'h100, 32'h101, 1'b1};
    if (obs !== exp_v) begin errors++; $display("FAIL stallsrc_target: got %h required %h", obs, exp_v); end
  endtask

  task automatic test_wrap;
    cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    checks++;
    exp_v = DS ? {1'b1, 32'hFFFF_FFFF, 32'h101, 32'h102, 1'b1} : {1'b1, 32'hFFFF_FFFF, 32'h0, 32'h101, 1'b0};
    if (obs !== exp_v) begin errors++; $display("FAIL wrap_setup: got %h required %h", obs, exp_v); end
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; exp_v = {1'b1, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b1};
    if (obs !== exp_v) begin errors++; $display("FAIL wrap_pc: got %h required %h", obs, exp_v); end
  endtask

  task automatic test_reset_mid;
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    imem_ready = 1'b1;
    imem_rdata = imem_addr;
    rst = 1'b1;
    #1;
    exp_v = {1'b0, 32'h0, 32'h0, 32'h0, 1'b0};
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rstmid_async: got %h required %h", obs, exp_v); end
    @(posedge clk); #1;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rstmid_edge: got %h required %h", obs, exp_v); end
    rst = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; exp_v = {1'b1, 32'h0, 32'h0, 32'h0, 1'b0};
    if (obs !== exp_v) begin errors++; $display("FAIL rstmid_refetch: got %h required %h", obs, exp_v); end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_stall;
    test_redirect_wait;
    test_redirect_ready;
    test_stall_redirect;
    test_wrap;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, word address of the first fetched instruction.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous reset, active-high.
REQ-004 ID_Stall  input  1  hazard stall; while high, the IF/ID register and the PC hold.
REQ-005 ID_PCSrc  input  1  redirect request from decode (taken branch, j, jr).
REQ-006 ID_PCBranch  input  32  redirect target, word address.
REQ-007 imem_req  output  1  instruction fetch request.
REQ-008 imem_addr  output  32  fetch word address.
REQ-009 imem_ready  input  1  fetch completes this cycle; imem_rdata is valid.
REQ-010 imem_rdata  input  32  fetched instruction.
REQ-011 IF_ID_Ins  output  32  registered instruction presented to decode.
REQ-012 IF_ID_PC_P1  output  32  registered address of IF_ID_Ins plus 1 (word units).
REQ-013 IF_ID_Valid  output  1  IF_ID_Ins holds a real instruction, not a bubble.

Function
REQ-014 PC is word-addressed; sequential increment is +1, modulo 2^32, with no wrap flag.
REQ-015 At most one fetch is outstanding; imem_addr and imem_req remain stable from assertion until the cycle imem_ready=1.
REQ-016 The FSM has four states: IDLE, WAIT, FULL and DRAIN.
REQ-017 IDLE lasts exactly one cycle after reset and has imem_req=0; it then moves to WAIT with imem_addr=PC.
REQ-018 In WAIT, imem_req=1.
- If imem_ready=1 and ID_Stall=0: IF/ID is loaded with {imem_rdata, PC+1, Valid=1}, PC<=PC+1, and the state stays WAIT (back-to-back fetch, one instruction per cycle at zero wait).
- If imem_ready=1 and ID_Stall=1: imem_rdata and PC+1 go to an internal holding buffer, and the state moves to FULL.
- If imem_ready=0 and ID_Stall=0: IF/ID is loaded with the bubble {32'h0, PC_P1 unchanged, Valid=0}.
REQ-019 In FULL, imem_req=0. When ID_Stall falls, the buffer moves into IF/ID with Valid=1, PC<=PC+1, and the state returns to WAIT.
REQ-020 A redirect is accepted on an edge where ID_PCSrc=1, ID_Stall=0 and IF_ID_Valid=1. ID_PCSrc is ignored while ID_Stall=1.
REQ-021 On redirect, the target is latched into redir_tgt and redir_pend is set; the redirect applies to the fetch currently in flight or buffered.
REQ-022 Redirect with a fetch still outstanding (no imem_ready that cycle): the state moves to DRAIN, imem_req stays high with the old address, and the completing word is disposed of per REQ-028/029. The next state is then WAIT with PC<=redir_tgt and redir_pend cleared.
REQ-023 Redirect coinciding with imem_ready=1, or from FULL: the word is disposed of per REQ-028/029 in that same edge, and PC<=ID_PCBranch.
REQ-024 A second ID_PCSrc while redir_pend=1 is ignored; IF_ID_Valid is 0 in that window whenever the delay slot is compiled out.
REQ-025 Latency: redirect edge to imem_addr=target is 1 cycle at zero wait, or (remaining wait + 1) cycles otherwise.

Reset
REQ-026 While rst is high, the following hold regardless of clk:
- PC=RESET_PC and state=IDLE
- imem_req=0 and imem_addr=RESET_PC
- IF_ID_Ins=32'h0, IF_ID_PC_P1=RESET_PC and IF_ID_Valid=0
- redir_pend=0, redir_tgt=0 and the holding buffer cleared
REQ-027 A reset asserted mid-fetch abandons the request; an imem_ready arriving in the first cycle after reset is ignored.

Configuration
REQ-028 With IF_DELAY_SLOT_EN defined, the word fetched after a redirecting instruction is the delay slot. It is delivered to IF/ID with Valid=1 (IF_ID_PC_P1 = its address + 1), and fetching then continues at the target.
REQ-029 Without IF_DELAY_SLOT_EN, that word is discarded: IF/ID receives the bubble (32'h0, Valid=0) and fetching continues at the target.

Verification
REQ-030 Reset, then zero-wait memory returning addr as data -> imem_addr is 0,1,2,3 on consecutive cycles; IF_ID_Ins is 0,1,2 with IF_ID_PC_P1 1,2,3 and Valid=1.
REQ-031 ID_Stall=1 for 3 cycles while the word at addr 5 returns -> IF/ID is held, imem_req=0 for 2 cycles, and word 5 appears in IF/ID the cycle after the stall drops.
REQ-032 ID_PCSrc=1 with target 32'h40 while the fetch of 8 is outstanding (2 wait states) -> imem_addr stays 8 until ready, then becomes 32'h40. IF/ID gets word 8 with Valid=1 with IF_DELAY_SLOT_EN, or a bubble without it.
REQ-033 ID_PCSrc=1 and ID_Stall=1 together -> no redirect, PC unchanged; ID_PCSrc=1 then taken the cycle after the stall drops.
REQ-034 rst pulsed during WAIT with imem_ready=1 that cycle -> outputs at reset values, no IF/ID load, and imem_addr=RESET_PC on the second cycle after rst falls.
REQ-035 PC=32'hFFFF_FFFF fetched -> next imem_addr=0 and IF_ID_PC_P1=0.
